solar_wb_regs: RTL and testbench
================================

SOLAR_WB_REGS -- requirements
Module: solar_wb_regs

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, the Wishbone base address; bits [3:0] are ignored.
REQ-002 SHALL have parameter DEPTH, default 16, the sample FIFO depth; it is a power of two, 2..32.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 wb_rst_i  input  1  synchronous active-high reset.
REQ-006 wbs_stb_i / wbs_cyc_i / wbs_we_i  input  1 each  Wishbone classic strobe, cycle, write-enable.
REQ-007 wbs_sel_i  input  4  byte-lane selects.
REQ-008 wbs_adr_i  input  32  byte address.
REQ-009 wbs_dat_i  input  32  write data.
REQ-010 wbs_ack_o  output  1  registered acknowledge.
REQ-011 wbs_dat_o  output  32  registered read data.
REQ-012 smp_valid_i  input  1  one-cycle sample strobe from the solar monitor core.
REQ-013 smp_data_i  input  12  sample value, qualified by smp_valid_i.
REQ-014 smp_en_o  output  1  sampling enable to the monitor core (CTRL.EN).
REQ-015 irq_o  output  1  level interrupt, routed to user_irq[0].

Function
REQ-016 Hit = cyc & stb & (adr[31:4] == BASE_ADDR[31:4]); non-hits SHALL be ignored, with no ack.
REQ-017 Ack on hit: wbs_ack_o SHALL be high exactly one cycle, the cycle after the hit, and low in the following cycle even if stb stays high; the next ack needs a new hit sampled while ack is low (at most one ack per two cycles).
REQ-018 Side effects (register write, FIFO pop) SHALL occur once per ack, in the cycle the hit is sampled.
REQ-019 wbs_dat_o SHALL be valid while ack is high and 0 otherwise.
REQ-020 Register map (offset adr[3:2]):
- 0x0 CTRL RW: bit0 EN; bit1 CLR (write-1, self-clearing, reads 0); other bits read 0.
- 0x4 STATUS: bit0 EMPTY; bit1 FULL; bit2 OVF sticky (write-1-to-clear); bits[10:4] COUNT; others 0.
- 0x8 DATA RO: read pops one entry; bit31 VALID, bits[11:0] sample; writes ignored.
- 0xC THRESH RW: bits[5:0]; others read 0.
REQ-021 Writes to CTRL, THRESH and STATUS SHALL take effect only if wbs_sel_i[0]=1.
REQ-022 Push: smp_valid_i & EN & !FULL SHALL write smp_data_i at the tail; it is readable from the next cycle.
REQ-023 Push while FULL with no pop that cycle SHALL drop the sample and set OVF.
REQ-024 Push and pop in the same cycle SHALL both occur, with COUNT unchanged; a push while FULL plus a pop SHALL succeed, with OVF unchanged.
REQ-025 A DATA read when EMPTY SHALL return 32'h0 and SHALL NOT change pointers.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; COUNT ranges 0..DEPTH.
REQ-027 CLR SHALL empty the FIFO in the write cycle; a simultaneous push SHALL be dropped, and OVF SHALL NOT be set by it.
REQ-028 smp_valid_i SHALL be ignored while EN=0; FIFO contents SHALL be retained when EN falls.
REQ-029 irq_o SHALL be registered: irq_o = EN & (THRESH!=0) & (COUNT>=THRESH) | OVF, updated the cycle after the condition changes.
REQ-030 smp_en_o SHALL equal the CTRL.EN register.

Reset
REQ-031 Under wb_rst_i: wbs_ack_o=0, wbs_dat_o=0, smp_en_o=0, irq_o=0, EN=0, THRESH=0, OVF=0, FIFO empty, COUNT=0.
REQ-032 Reset asserted during a pending hit SHALL abort it: no ack and no side effect.
REQ-033 Reset SHALL override all simultaneous pushes, pops and writes.

Verification
REQ-034 Write CTRL=0x1, then three samples 0x0A1, 0x0A2, 0x0A3 -> STATUS reads COUNT=3, EMPTY=0; DATA reads return 0x8000_00A1, 0x8000_00A2, 0x8000_00A3, then 0x0.
REQ-035 EN=1, DEPTH+2 samples with no reads -> FULL=1, OVF=1, irq_o=1; write STATUS=0x4 -> OVF=0, and irq_o falls one cycle later (THRESH=0).
REQ-036 THRESH=4, EN=1, push 4 samples -> irq_o rises the cycle after the 4th push; one DATA read -> irq_o falls.
REQ-037 FULL FIFO: DATA read in the same cycle as smp_valid_i -> COUNT stays DEPTH, OVF stays 0, the order of the remaining samples is preserved.
REQ-038 stb/cyc held high for 4 cycles on DATA -> exactly 2 acks, 2 pops; access at BASE_ADDR+0x10 -> no ack; reset mid-access -> no ack, all outputs 0.

Source files
------------

// File: rtl/solar_wb_regs_if.sv
// ---------------------------------------------------------------------------
// solar_wb_regs_if
// Wishbone classic slave bus bundle for the solar monitor register block.
//   wbs_stb_i / wbs_cyc_i / wbs_we_i : strobe, cycle, write-enable
//   wbs_sel_i [3:0]                  : byte-lane selects
//   wbs_adr_i [31:0]                 : byte address
//   wbs_dat_i [31:0]                 : write data
//   wbs_ack_o                        : acknowledge (driven by the slave)
//   wbs_dat_o [31:0]                 : read data (driven by the slave)
// Modports: master drives the request side, slave drives ack/read data.
// ---------------------------------------------------------------------------
interface solar_wb_regs_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/solar_wb_regs.sv
// ---------------------------------------------------------------------------
// solar_wb_regs
// Wishbone register block for the solar monitor: control, status, a sample
// FIFO fed by the monitor core, a FIFO-level threshold and a level interrupt.
// Ports:
//   wb_clk_i     : sole clock, rising edge
//   wb_rst_i     : synchronous active-high reset
//   wbs          : Wishbone classic slave (solar_wb_regs_if.slave)
//   smp_valid_i  : one-cycle sample strobe from the monitor core
//   smp_data_i   : 12-bit sample, qualified by smp_valid_i
//   smp_en_o     : sampling enable (CTRL.EN)
//   irq_o        : registered level interrupt
// Register map (adr[3:2]): 0 CTRL, 1 STATUS, 2 DATA (pop on read), 3 THRESH.
// ---------------------------------------------------------------------------
module solar_wb_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  solar_wb_regs_if.slave        wbs,
  input  logic                  smp_valid_i,
  input  logic [11:0]           smp_data_i,
  output logic                  smp_en_o,
  output logic                  irq_o
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Register state
  logic              r_ack;
  logic [31:0]       r_dat;
  logic              r_en;
  logic [5:0]        r_thresh;
  logic              r_ovf;
  logic              r_irq;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [11:0]       r_mem [DEPTH];

  // Decode / datapath wires
  logic              w_hit;
  logic              w_accept;
  logic [1:0]        w_off;
  logic              w_wr_sel0;
  logic              w_ctrl_wr;
  logic              w_clr;
  logic              w_thr_wr;
  logic              w_ovf_clr;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_ovf_set;
  logic [11:0]       w_head;
  logic [31:0]       w_rd_data;
  logic              w_irq_next;
  logic              w_unused_bits;

  // A hit only starts a transfer while ack is low, so a held strobe gets
  // at most one ack every two cycles and each ack carries one side effect.
  assign w_hit     = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                     (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_accept  = w_hit & ~r_ack;
  assign w_off     = wbs.wbs_adr_i[3:2];
  assign w_wr_sel0 = w_accept & wbs.wbs_we_i & wbs.wbs_sel_i[0];

  assign w_ctrl_wr = w_wr_sel0 & (w_off == 2'd0);
  assign w_clr     = w_ctrl_wr & wbs.wbs_dat_i[1];
  assign w_ovf_clr = w_wr_sel0 & (w_off == 2'd1) & wbs.wbs_dat_i[2];
  assign w_thr_wr  = w_wr_sel0 & (w_off == 2'd3);

  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_head    = r_mem[r_rd_ptr];
  assign w_pop     = w_accept & ~wbs.wbs_we_i & (w_off == 2'd2) & ~w_empty;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // only lost when nothing leaves. CLR discards the push without flagging it.
  assign w_push_req = smp_valid_i & r_en & ~w_clr;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;

  assign w_irq_next = (r_en & (r_thresh != 6'd0) &
                       (7'(r_count) >= 7'(r_thresh))) | r_ovf;

  // Bits of the bus that no register decodes.
  assign w_unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:6],
                           wbs.wbs_dat_i[4:3], wbs.wbs_sel_i[3:1]};

  // Read-data mux from the pre-access register state.
  always_comb begin
    w_rd_data = 32'h0000_0000;
    case (w_off)
      2'd0: w_rd_data = {31'd0, r_en};
      2'd1: w_rd_data = {21'd0, 7'(r_count), 1'b0, r_ovf, w_full, w_empty};
      2'd2: begin
        if (w_empty) begin
          w_rd_data = 32'h0000_0000;
        end else begin
          w_rd_data = {1'b1, 19'd0, w_head};
        end
      end
      2'd3: w_rd_data = {26'd0, r_thresh};
      default: w_rd_data = 32'h0000_0000;
    endcase
  end

  // Bus response: one-cycle ack with read data, zero data otherwise.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0000_0000;
    end else begin
      r_ack <= w_accept;
      r_dat <= (w_accept & ~wbs.wbs_we_i) ? w_rd_data : 32'h0000_0000;
    end
  end

  // Control, threshold and sticky overflow registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_en     <= 1'b0;
      r_thresh <= 6'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_en <= wbs.wbs_dat_i[0];
      end
      if (w_thr_wr) begin
        r_thresh <= wbs.wbs_dat_i[5:0];
      end
      // A new overflow event wins over a simultaneous clear.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || w_clr) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // Sample storage; contents are meaningless while the count says empty.
  always_ff @(posedge wb_clk_i) begin
    if (w_push && !wb_rst_i) begin
      r_mem[r_wr_ptr] <= smp_data_i;
    end
  end

  // Interrupt lags the register state by one cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_next;
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign smp_en_o      = r_en;
  assign irq_o         = r_irq;

endmodule

// File: tb/tb_solar_wb_regs.sv
module tb_solar_wb_regs;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        smp_valid = 1'b0;
  logic [11:0] smp_data = 12'h000;
  logic        smp_en;
  logic        irq;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_on  = 1'b0;

  solar_wb_regs_if bus ();

  solar_wb_regs #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs         (bus),
    .smp_valid_i (smp_valid),
    .smp_data_i  (smp_data),
    .smp_en_o    (smp_en),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [11:0] q[$];
  bit          m_en = 1'b0;
  int          m_thr = 0;
  bit          m_ovf = 1'b0;
  bit          exp_ack = 1'b0;
  bit          exp_rd = 1'b0;
  bit          exp_irq = 1'b0;
  logic [31:0] exp_dat = 32'h0;

  initial begin : model
    bit          acc, clr, pop, w1c, set_ovf, pre_en, irqn;
    int          n;
    logic [31:0] rv;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_en = 1'b0; m_thr = 0; m_ovf = 1'b0;
        exp_ack = 1'b0; exp_rd = 1'b0; exp_dat = 32'h0; exp_irq = 1'b0;
      end else begin
        n      = q.size();
        pre_en = m_en;
        irqn   = (m_en && m_thr != 0 && n >= m_thr) || m_ovf;
        acc    = bus.wbs_cyc_i && bus.wbs_stb_i &&
                 ((bus.wbs_adr_i >> 4) == (BASE >> 4)) && !exp_ack;
        rv = 32'h0; clr = 1'b0; pop = 1'b0; w1c = 1'b0; set_ovf = 1'b0;
        if (acc) begin
          case (bus.wbs_adr_i[3:2])
            2'd0: if (bus.wbs_we_i) begin
                    if (bus.wbs_sel_i[0]) begin
                      m_en = bus.wbs_dat_i[0];
                      clr  = bus.wbs_dat_i[1];
                    end
                  end else rv = {31'd0, m_en};
            2'd1: if (bus.wbs_we_i) w1c = bus.wbs_sel_i[0] && bus.wbs_dat_i[2];
                  else rv = {21'd0, 7'(n), 1'b0, m_ovf, n == DEPTH, n == 0};
            2'd2: if (!bus.wbs_we_i && n > 0) begin
                    rv  = 32'h8000_0000 | {20'd0, q[0]};
                    pop = 1'b1;
                  end
            default: if (bus.wbs_we_i) begin
                    if (bus.wbs_sel_i[0]) m_thr = int'(bus.wbs_dat_i[5:0]);
                  end else rv = m_thr;
          endcase
        end
        if (clr) q.delete();
        else begin
          if (pop) void'(q.pop_front());
          if (smp_valid && pre_en) begin
            if (q.size() < DEPTH) q.push_back(smp_data);
            else set_ovf = 1'b1;
          end
        end
        if (set_ovf) m_ovf = 1'b1;
        else if (w1c) m_ovf = 1'b0;
        exp_ack = acc;
        exp_rd  = acc && !bus.wbs_we_i;
        exp_dat = exp_rd ? rv : 32'h0;
        exp_irq = irqn;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack", {31'd0, bus.wbs_ack_o}, {31'd0, exp_ack});
      if (!exp_ack || exp_rd) chk("dat_o", bus.wbs_dat_o, exp_dat);
      chk("smp_en", {31'd0, smp_en}, {31'd0, m_en});
      chk("irq", {31'd0, irq}, {31'd0, exp_irq});
    end
  end

  // ---------------- bus / sample helpers ----------------
  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           output logic [31:0] rdata);
    logic acked;
    acked = 1'b0;
    rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = adr; bus.wbs_dat_i = dat;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rdata = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    chk("ack_timeout", {31'd0, acked}, 32'd1);
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] dat);
    logic [31:0] d;
    wb_access(1'b1, BASE + {28'd0, off}, dat, d);
  endtask

  task automatic wb_read_chk(input string nm, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d;
    wb_access(1'b0, BASE + {28'd0, off}, 32'h0, d);
    chk(nm, d, exp);
  endtask

  task automatic push(input logic [11:0] v);
    @(negedge clk);
    smp_valid = 1'b1; smp_data = v;
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int          acks;
    logic [31:0] cap [2];
    int          hold;
    int          r;
    logic [31:0] d;

    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("rst_dat", bus.wbs_dat_o, 32'd0);
    chk("rst_en", {31'd0, smp_en}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // Basic FIFO readback
    wb_write(4'h0, 32'h1);
    push(12'h0A1); push(12'h0A2); push(12'h0A3);
    wb_read_chk("basic_status", 4'h4, 32'h0000_0030);
    wb_read_chk("basic_d0", 4'h8, 32'h8000_00A1);
    wb_read_chk("basic_d1", 4'h8, 32'h8000_00A2);
    wb_read_chk("basic_d2", 4'h8, 32'h8000_00A3);
    wb_read_chk("basic_empty", 4'h8, 32'h0000_0000);
    wb_read_chk("ctrl_rd", 4'h0, 32'h0000_0001);

    // Overflow and W1C
    for (int i = 0; i < DEPTH + 2; i++) push(12'(i));
    wb_read_chk("ovf_status", 4'h4, 32'h0000_0106);
    chk("ovf_irq", {31'd0, irq}, 32'd1);
    wb_write(4'h4, 32'h4);
    chk("ovf_irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("ovf_irq_fall", {31'd0, irq}, 32'd0);
    wb_read_chk("ovf_cleared", 4'h4, 32'h0000_0102);

    // Threshold interrupt
    wb_write(4'h0, 32'h3);
    wb_write(4'hC, 32'hFFFF_FFC4);
    wb_read_chk("thresh_rd", 4'hC, 32'h0000_0004);
    push(12'h011); push(12'h012); push(12'h013); push(12'h014);
    chk("thr_irq_pre", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("thr_irq_rise", {31'd0, irq}, 32'd1);
    wb_read_chk("thr_pop", 4'h8, 32'h8000_0011);
    @(negedge clk);
    chk("thr_irq_fall", {31'd0, irq}, 32'd0);

    // Full FIFO: simultaneous pop and push
    wb_write(4'h0, 32'h3);
    wb_write(4'hC, 32'h0);
    for (int i = 0; i < DEPTH; i++) push(12'h100 + 12'(i));
    wb_read_chk("full_status", 4'h4, 32'h0000_0102);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE + 32'h8; smp_valid = 1'b1; smp_data = 12'h1FF;
    @(negedge clk);
    smp_valid = 1'b0;
    chk("pp_ack", {31'd0, bus.wbs_ack_o}, 32'd1);
    chk("pp_dat", bus.wbs_dat_o, 32'h8000_0100);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    wb_read_chk("pp_status", 4'h4, 32'h0000_0102);
    for (int i = 1; i < DEPTH; i++) wb_read_chk("pp_order", 4'h8, 32'h8000_0100 + i);
    wb_read_chk("pp_last", 4'h8, 32'h8000_01FF);
    wb_read_chk("pp_empty", 4'h8, 32'h0);

    // Held strobe: two acks in four cycles
    push(12'h0B1); push(12'h0B2); push(12'h0B3);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE + 32'h8;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        if (acks < 2) cap[acks] = bus.wbs_dat_o;
        acks++;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    chk("held_acks", acks, 32'd2);
    chk("held_d0", cap[0], 32'h8000_00B1);
    chk("held_d1", cap[1], 32'h8000_00B2);
    wb_read_chk("held_status", 4'h4, 32'h0000_0010);

    // Out-of-window address
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = BASE + 32'h10;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) acks++;
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    chk("miss_acks", acks, 32'd0);

    // Reset during a pending hit
    wb_write(4'hC, 32'h1);
    @(negedge clk);
    chk("prerst_irq", {31'd0, irq}, 32'd1);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = BASE + 32'h8;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("rst_mid_dat", bus.wbs_dat_o, 32'd0);
    chk("rst_mid_en", {31'd0, smp_en}, 32'd0);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    wb_read_chk("rst_mid_status", 4'h4, 32'h0000_0001);

    // Randomized traffic against the model
    hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      smp_valid = (cyc < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      smp_data  = 12'($urandom);
      if (bus.wbs_stb_i) begin
        if (hold == 0) begin
          bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        end else hold--;
      end else if ($urandom_range(0, 2) == 0) begin
        hold = $urandom_range(0, 3);
        r = $urandom_range(0, 11);
        if (r < 10) bus.wbs_adr_i = BASE + {28'd0, 2'(r % 4), 2'($urandom)};
        else if (r == 10) bus.wbs_adr_i = BASE + 32'h10 + {28'd0, 4'($urandom)};
        else bus.wbs_adr_i = $urandom;
        if (r == 2 || r == 6 || r == 9) bus.wbs_adr_i[3:2] = 2'd2;
        d = $urandom;
        d[0] = ($urandom_range(0, 4) != 0);
        d[1] = ($urandom_range(0, 11) == 0);
        bus.wbs_dat_i = d;
        bus.wbs_we_i  = ($urandom_range(0, 2) == 0);
        bus.wbs_sel_i = 4'($urandom);
        bus.wbs_cyc_i = ($urandom_range(0, 9) != 0);
        bus.wbs_stb_i = 1'b1;
      end
    end
    rst = 1'b0; smp_valid = 1'b0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    repeat (4) @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
